// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// imem_loader
//
// Write side of the instruction memory. A byte stream arrives over a
// valid/ready handshake: first a header byte holding the word count N, then
// 4*N data bytes. The bytes are assembled big-endian into 32-bit words and
// committed one at a time through a single-cycle write strobe. The pipeline
// is expected to be stalled while a session runs.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one trailing byte follows the last word. It must equal the
//   XOR of all 4*N data bytes (header excluded); a mismatch sets err. Words
//   already written are kept either way.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          single-cycle pulse, begins a session from IDLE or DONE
//   byte_in        stream byte
//   byte_valid     byte_in is valid this cycle
//   byte_ready     loader accepts a byte this cycle
//   imem_we        instruction memory write strobe, one cycle per word
//   imem_addr      word address of the write
//   imem_wdata     assembled instruction word
//   busy           session in progress
//   done           session finished, held until the next start
//   err            session failed, valid while done=1
//   words_written  number of words committed this session
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_written
);

    // Header values above this are rejected without writing anything.
    localparam logic [7:0]  DEPTH_B  = 8'(DEPTH);
    localparam logic [AW:0] ONE_W    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] ZERO_W   = {(AW+1){1'b0}};
    localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_A  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_RECV  = 3'd2,
        S_WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK   = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    // Shift a new byte into the low end; after four bytes the first one
    // received sits in bits 31:24.
    function automatic logic [31:0] shift_in(input logic [31:0] word,
                                             input logic [7:0]  b);
        return {word[23:0], b};
    endfunction

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of the data bytes, checked against the trailing byte.
    function automatic logic [7:0] xor_acc(input logic [7:0] acc,
                                           input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_t        state_r;
    logic          byte_ready_r;
    logic          imem_we_r;
    logic [AW-1:0] imem_addr_r;
    logic [31:0]   imem_wdata_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;
    logic [AW:0]   words_written_r;
    logic [AW:0]   n_r;
    logic [AW-1:0] word_idx_r;
    logic [1:0]    byte_idx_r;
    logic [31:0]   word_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_r;
`endif

    logic          accept_s;
    logic          last_word_s;

    assign accept_s    = byte_valid && byte_ready_r;
    // True in WRITE when the word being committed is the Nth one.
    assign last_word_s = ((words_written_r + ONE_W) == n_r);

    // Session FSM; every output is a register updated with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            byte_ready_r    <= 1'b0;
            imem_we_r       <= 1'b0;
            imem_addr_r     <= ZERO_A;
            imem_wdata_r    <= 32'h0000_0000;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            err_r           <= 1'b0;
            words_written_r <= ZERO_W;
            n_r             <= ZERO_W;
            word_idx_r      <= ZERO_A;
            byte_idx_r      <= 2'd0;
            word_r          <= 32'h0000_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r          <= 8'h00;
`endif
        end else begin
            // The strobe is only ever raised for the single WRITE cycle.
            imem_we_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r      <= S_HDR;
                        busy_r       <= 1'b1;
                        byte_ready_r <= 1'b1;
                    end else begin
                        state_r      <= S_IDLE;
                    end
                end

                S_HDR: begin
                    if (accept_s) begin
                        words_written_r <= ZERO_W;
                        word_idx_r      <= ZERO_A;
                        byte_idx_r      <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r          <= 8'h00;
`endif
                        if (byte_in == 8'h00) begin
                            state_r      <= S_DONE;
                            byte_ready_r <= 1'b0;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                            err_r        <= 1'b0;
                        end else if (byte_in > DEPTH_B) begin
                            state_r      <= S_DONE;
                            byte_ready_r <= 1'b0;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                            err_r        <= 1'b1;
                        end else begin
                            // Fits in AW+1 bits because N <= DEPTH <= 2**AW.
                            n_r          <= byte_in[AW:0];
                            state_r      <= S_RECV;
                        end
                    end else begin
                        state_r <= S_HDR;
                    end
                end

                S_RECV: begin
                    if (accept_s) begin
                        word_r <= shift_in(word_r, byte_in);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r <= xor_acc(csum_r, byte_in);
`endif
                        if (byte_idx_r == 2'd3) begin
                            // Fourth byte: present the word on the very next
                            // cycle, which is the WRITE cycle.
                            state_r      <= S_WRITE;
                            byte_ready_r <= 1'b0;
                            byte_idx_r   <= 2'd0;
                            imem_we_r    <= 1'b1;
                            imem_addr_r  <= word_idx_r;
                            imem_wdata_r <= shift_in(word_r, byte_in);
                        end else begin
                            byte_idx_r   <= byte_idx_r + 2'd1;
                            state_r      <= S_RECV;
                        end
                    end else begin
                        state_r <= S_RECV;
                    end
                end

                S_WRITE: begin
                    word_idx_r      <= word_idx_r + ONE_A;
                    words_written_r <= words_written_r + ONE_W;
                    if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_r      <= S_CHK;
                        byte_ready_r <= 1'b1;
`else
                        state_r      <= S_DONE;
                        byte_ready_r <= 1'b0;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        err_r        <= 1'b0;
`endif
                    end else begin
                        state_r      <= S_RECV;
                        byte_ready_r <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept_s) begin
                        state_r      <= S_DONE;
                        byte_ready_r <= 1'b0;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        err_r        <= (byte_in != csum_r);
                    end else begin
                        state_r <= S_CHK;
                    end
                end
`endif

                S_DONE: begin
                    if (start) begin
                        state_r      <= S_HDR;
                        byte_ready_r <= 1'b1;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        err_r        <= 1'b0;
                    end else begin
                        state_r      <= S_DONE;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a quiet IDLE.
                    state_r      <= S_IDLE;
                    byte_ready_r <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    err_r        <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready    = byte_ready_r;
    assign imem_we       = imem_we_r;
    assign imem_addr     = imem_addr_r;
    assign imem_wdata    = imem_wdata_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign words_written = words_written_r;

    imem_loader_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_ready (byte_ready_r),
        .imem_we    (imem_we_r),
        .busy       (busy_r),
        .done       (done_r)
    );

endmodule

// -----------------------------------------------------------------------------
// imem_loader_chk
//
// Structural invariants of the loader outputs.
//
// Ports:
//   clk, rst_n   clock and reset of the observed loader
//   byte_ready   loader handshake ready
//   imem_we      loader write strobe
//   busy, done   loader session status
// -----------------------------------------------------------------------------
module imem_loader_chk (
    input logic clk,
    input logic rst_n,
    input logic byte_ready,
    input logic imem_we,
    input logic busy,
    input logic done
);

    // A write only happens inside a session.
    a_we_busy: assert property (@(posedge clk) disable iff (!rst_n)
        imem_we |-> busy)
        else $error("imem_loader: imem_we outside a session");

    // No byte is taken during the write cycle.
    a_we_noready: assert property (@(posedge clk) disable iff (!rst_n)
        imem_we |-> !byte_ready)
        else $error("imem_loader: byte_ready during write");

    // Ready only while a session runs.
    a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
        byte_ready |-> busy)
        else $error("imem_loader: byte_ready while idle");

    // done and busy are mutually exclusive.
    a_done_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(done && busy))
        else $error("imem_loader: done and busy together");

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [5:0]  words_written;

    int total = 0;
    int bad   = 0;
    int we_count = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    imem_loader #(.DEPTH(32), .AW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            we_count++;
            chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e.addr));
                chk("write_data", imem_wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one byte until it is taken (bounded), then drop valid.
    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [4:0] addr, input logic [31:0] w);
        exp_q.push_back('{addr: addr, data: w});
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
        chk("write_latency", 32'(imem_we), 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    // Full session with up to two words (and the correct checksum if built in).
    task automatic session(input logic [7:0] n, input logic [31:0] w0, input logic [31:0] w1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] ck;
        ck = w0[31:24] ^ w0[23:16] ^ w0[15:8] ^ w0[7:0];
        if (n > 8'd1) ck = ck ^ w1[31:24] ^ w1[23:16] ^ w1[15:8] ^ w1[7:0];
`endif
        pulse_start();
        send_byte(n);
        send_word(5'd0, w0);
        if (n > 8'd1) send_word(5'd1, w1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(ck);
`endif
        wait_done();
    endtask

    initial begin
        logic       tv [0:6];
        logic [7:0] tb_bytes [0:3];
        int k;

        rst_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we",    32'(imem_we), 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-word program at full rate.
        we_count = 0;
        session(8'h02, 32'h8C01_0001, 32'hAC04_0001);
        chk("t1_err",   32'(err), 32'd0);
        chk("t1_words", 32'(words_written), 32'd2);
        chk("t1_busy",  32'(busy), 32'd0);
        chk("t1_we_count", 32'(we_count), 32'd2);
        chk("t1_queue", 32'(exp_q.size()), 32'd0);

        // Empty program.
        we_count = 0;
        pulse_start();
        chk("t2_cleared_done", 32'(done), 32'd0);
        send_byte(8'h00);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_err",  32'(err), 32'd0);
        chk("t2_words", 32'(words_written), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_we_count", 32'(we_count), 32'd0);

        // Oversized header: rejected, later bytes refused.
        we_count = 0;
        pulse_start();
        send_byte(8'h21);
        chk("t3_done",  32'(done), 32'd1);
        chk("t3_err",   32'(err), 32'd1);
        chk("t3_words", 32'(words_written), 32'd0);
        byte_in = 8'h55; byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_ready", 32'(byte_ready), 32'd0);
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        chk("t3_we_count", 32'(we_count), 32'd0);

        // N=1 with a gappy source; valid held high across the write cycle.
        we_count = 0;
        tv[0] = 1'b1; tv[1] = 1'b0; tv[2] = 1'b0; tv[3] = 1'b1;
        tv[4] = 1'b0; tv[5] = 1'b1; tv[6] = 1'b1;
        tb_bytes[0] = 8'h00; tb_bytes[1] = 8'h21; tb_bytes[2] = 8'h08; tb_bytes[3] = 8'h21;
        pulse_start();
        send_byte(8'h01);
        exp_q.push_back('{addr: 5'd0, data: 32'h0021_0821});
        k = 0;
        for (int i = 0; i < 7; i++) begin
            byte_valid = tv[i];
            byte_in    = tv[i] ? tb_bytes[k] : 8'hEE;
            @(posedge clk); #1;
            if (tv[i]) k++;
        end
        byte_valid = 1'b1; byte_in = 8'hFF;
        chk("t4_latency", 32'(imem_we), 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
        chk("t4_words", 32'(words_written), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h08);
`endif
        wait_done();
        chk("t4_err", 32'(err), 32'd0);
        chk("t4_we_count", 32'(we_count), 32'd1);

        // Reset in the middle of word 1 of a three-word load.
        pulse_start();
        send_byte(8'h03);
        send_word(5'd0, 32'h1122_3344);
        send_byte(8'h55);
        send_byte(8'h66);
        rst_n = 1'b0;
        #1;
        chk("t5_busy",  32'(busy), 32'd0);
        chk("t5_ready", 32'(byte_ready), 32'd0);
        chk("t5_done",  32'(done), 32'd0);
        chk("t5_err",   32'(err), 32'd0);
        chk("t5_we",    32'(imem_we), 32'd0);
        chk("t5_addr",  32'(imem_addr), 32'd0);
        chk("t5_wdata", imem_wdata, 32'd0);
        chk("t5_words", 32'(words_written), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        session(8'h01, 32'hCAFE_F00D, 32'h0000_0000);
        chk("t5_reload_err",   32'(err), 32'd0);
        chk("t5_reload_words", 32'(words_written), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Trailing checksum: 12^34^56^78 = 08.
        pulse_start();
        send_byte(8'h01);
        send_word(5'd0, 32'h1234_5678);
        send_byte(8'h08);
        wait_done();
        chk("t6_good_err", 32'(err), 32'd0);
        pulse_start();
        send_byte(8'h01);
        send_word(5'd0, 32'h1234_5678);
        send_byte(8'h09);
        wait_done();
        chk("t6_bad_err", 32'(err), 32'd1);
        chk("t6_bad_words", 32'(words_written), 32'd1);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
